// File: rtl/ulpi_pkg.sv
// Shared definitions for the ULPI register-port scheduler: state codes,
// PHY register addresses and the fixed init table.
package ulpi_pkg;

    localparam logic [2:0] ST_RESET      = 3'd0;
    localparam logic [2:0] ST_INIT_ISSUE = 3'd1;
    localparam logic [2:0] ST_ISSUE      = 3'd2;
    localparam logic [2:0] ST_WAIT       = 3'd3;
    localparam logic [2:0] ST_GAP        = 3'd4;
    localparam logic [2:0] ST_IDLE       = 3'd5;

    localparam logic [5:0] FUNC_CTRL = 6'h04;
    localparam logic [5:0] IFC_CTRL  = 6'h07;
    localparam logic [5:0] OTG_CTRL  = 6'h0A;

    localparam int INIT_LEN = 3;

    typedef struct packed {
        logic       rw;
        logic [5:0] addr;
        logic [7:0] wdata;
    } reg_op_t;

    function automatic logic [5:0] init_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    return FUNC_CTRL;
            2'd1:    return IFC_CTRL;
            default: return OTG_CTRL;
        endcase
    endfunction

    function automatic logic [7:0] init_data(input logic [1:0] idx);
        return (idx == 2'd0) ? 8'h65 : 8'h00;
    endfunction

    // FUNC_CTRL reset bit self-clears, so it is excluded from readback.
    function automatic logic [7:0] init_mask(input logic [1:0] idx);
        return (idx == 2'd0) ? 8'h5F : 8'hFF;
    endfunction

endpackage

// File: rtl/ulpi_reg_sched_if.sv
// Bus bundles for the scheduler: wrapper register port and the two-client side.
interface ulpi_reg_if;
    logic       ULPI_READY;
    logic       ULPI_REG_EN;
    logic       ULPI_REG_RW;
    logic [5:0] ULPI_REG_ADDR;
    logic [7:0] ULPI_REG_WDATA;
    logic [7:0] ULPI_REG_RDATA;
    logic       ULPI_REG_DONE;
    logic       ULPI_REG_FAIL;

    modport master (
        input  ULPI_READY, ULPI_REG_RDATA, ULPI_REG_DONE, ULPI_REG_FAIL,
        output ULPI_REG_EN, ULPI_REG_RW, ULPI_REG_ADDR, ULPI_REG_WDATA
    );
    modport slave (
        output ULPI_READY, ULPI_REG_RDATA, ULPI_REG_DONE, ULPI_REG_FAIL,
        input  ULPI_REG_EN, ULPI_REG_RW, ULPI_REG_ADDR, ULPI_REG_WDATA
    );
endinterface

interface ulpi_client_if;
    logic [1:0]  C_REQ;
    logic [1:0]  C_RW;
    logic [11:0] C_ADDR;
    logic [15:0] C_WDATA;
    logic [1:0]  C_GNT;
    logic [1:0]  C_DONE;
    logic [1:0]  C_ERR;
    logic [7:0]  C_RDATA;
    logic        INIT_DONE;
    logic        INIT_ERR;
    logic        BUSY;

    modport master (
        output C_REQ, C_RW, C_ADDR, C_WDATA,
        input  C_GNT, C_DONE, C_ERR, C_RDATA, INIT_DONE, INIT_ERR, BUSY
    );
    modport slave (
        input  C_REQ, C_RW, C_ADDR, C_WDATA,
        output C_GNT, C_DONE, C_ERR, C_RDATA, INIT_DONE, INIT_ERR, BUSY
    );
endinterface

// File: rtl/ulpi_reg_rr_arb.sv
// Two-way round-robin picker; last_i=1 means client 1 was served most recently.
module ulpi_reg_rr_arb (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);
    always_comb begin
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end
endmodule

// File: rtl/ulpi_reg_sched.sv
// ULPI register-port scheduler: PHY init table after reset, then round-robin clients.
// Optional macro ULPI_REG_INIT_VERIFY_EN adds readback/compare of every init write.
module ulpi_reg_sched
    import ulpi_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int MAX_RETRY   = 3
) (
    input  logic         CLK_60M,
    input  logic         RST_A_USB,
    ulpi_reg_if.master   ulpi,
    ulpi_client_if.slave cl
);
    logic [2:0] state_q, state_d;
    logic [1:0] idx_q, idx_d, nidx;
    logic [2:0] retry_q, retry_d;
    logic [7:0] tmo_q, tmo_d;
    logic [1:0] gnt_q, gnt_d, pick;
    logic       last_q, last_d;
    reg_op_t    op_q, op_d;
    logic [1:0] done_q, done_d, err_q, err_d;
    logic [7:0] rdata_q, rdata_d;
    logic       init_done_q, init_done_d, init_err_q, init_err_d;
    logic       again_q, again_d;
    logic       busy_q;
    logic       att_ok, att_fail, load_init, in_init, port_quiet;
`ifdef ULPI_REG_INIT_VERIFY_EN
    logic       rd_ph_q, rd_ph_d;
`endif

    assign in_init    = ~init_done_q;
    assign port_quiet = ~ulpi.ULPI_REG_DONE & ~ulpi.ULPI_REG_FAIL & ulpi.ULPI_READY;

    ulpi_reg_rr_arb u_arb (
        .req_i  (cl.C_REQ),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        tmo_d       = tmo_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        op_d        = op_q;
        done_d      = 2'b00;
        err_d       = 2'b00;
        rdata_d     = rdata_q;
        init_done_d = init_done_q;
        init_err_d  = init_err_q;
        again_d     = again_q;
`ifdef ULPI_REG_INIT_VERIFY_EN
        rd_ph_d     = rd_ph_q;
`endif
        att_ok      = 1'b0;
        att_fail    = 1'b0;
        load_init   = 1'b0;
        nidx        = idx_q + 2'd1;

        case (state_q)
            ST_RESET: begin
                nidx      = 2'd0;
                load_init = 1'b1;
            end
            ST_INIT_ISSUE, ST_ISSUE: begin
                tmo_d   = 8'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                tmo_d = tmo_q + 8'd1;
                if (ulpi.ULPI_REG_DONE) begin
`ifdef ULPI_REG_INIT_VERIFY_EN
                    if (in_init && !rd_ph_q) begin
                        rd_ph_d   = 1'b1;
                        op_d.rw   = 1'b0;
                        again_d   = 1'b1;
                        state_d   = ST_GAP;
                    end else if (in_init && (((ulpi.ULPI_REG_RDATA ^ init_data(idx_q))
                                              & init_mask(idx_q)) != 8'h00)) begin
                        att_fail = 1'b1;
                    end else begin
                        att_ok = 1'b1;
                    end
`else
                    att_ok = 1'b1;
`endif
                end else if (ulpi.ULPI_REG_FAIL || tmo_q == 8'(TIMEOUT_CYC)) begin
                    att_fail = 1'b1;
                end
            end
            ST_GAP: begin
                if (port_quiet) begin
                    if (again_q)
                        state_d = in_init ? ST_INIT_ISSUE : ST_ISSUE;
                    else if (!in_init)
                        state_d = ST_IDLE;
                    else if (idx_q == 2'(INIT_LEN - 1)) begin
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else
                        load_init = 1'b1;
                end
            end
            ST_IDLE: begin
                if (ulpi.ULPI_READY && (cl.C_REQ != 2'b00) && init_done_q) begin
                    gnt_d      = pick;
                    op_d.rw    = pick[1] ? cl.C_RW[1]       : cl.C_RW[0];
                    op_d.addr  = pick[1] ? cl.C_ADDR[11:6]  : cl.C_ADDR[5:0];
                    op_d.wdata = pick[1] ? cl.C_WDATA[15:8] : cl.C_WDATA[7:0];
                    retry_d    = 3'd0;
                    again_d    = 1'b0;
                    state_d    = ST_ISSUE;
                end
            end
            default: state_d = ST_RESET;
        endcase

        if (att_ok) begin
            again_d = 1'b0;
            state_d = ST_GAP;
            if (!in_init) begin
                done_d = gnt_q;
                gnt_d  = 2'b00;
                last_d = gnt_q[1];
                if (!op_q.rw)
                    rdata_d = ulpi.ULPI_REG_RDATA;
            end
        end

        if (att_fail) begin
            state_d = ST_GAP;
            if (retry_q < 3'(MAX_RETRY)) begin
                retry_d = retry_q + 3'd1;
                again_d = 1'b1;
`ifdef ULPI_REG_INIT_VERIFY_EN
                if (in_init) begin
                    rd_ph_d = 1'b0;
                    op_d.rw = 1'b1;
                end
`endif
            end else begin
                again_d = 1'b0;
                if (in_init)
                    init_err_d = 1'b1;
                else begin
                    err_d  = gnt_q;
                    gnt_d  = 2'b00;
                    last_d = gnt_q[1];
                end
            end
        end

        if (load_init) begin
            idx_d   = nidx;
            op_d    = '{rw: 1'b1, addr: init_addr(nidx), wdata: init_data(nidx)};
            retry_d = 3'd0;
            again_d = 1'b0;
            state_d = ST_INIT_ISSUE;
`ifdef ULPI_REG_INIT_VERIFY_EN
            rd_ph_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge CLK_60M or posedge RST_A_USB) begin
        if (RST_A_USB) begin
            state_q     <= ST_RESET;
            idx_q       <= 2'd0;
            retry_q     <= 3'd0;
            tmo_q       <= 8'd0;
            gnt_q       <= 2'b00;
            last_q      <= 1'b1;
            op_q        <= '0;
            done_q      <= 2'b00;
            err_q       <= 2'b00;
            rdata_q     <= 8'h00;
            init_done_q <= 1'b0;
            init_err_q  <= 1'b0;
            again_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ULPI_REG_INIT_VERIFY_EN
            rd_ph_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            tmo_q       <= tmo_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            op_q        <= op_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            init_done_q <= init_done_d;
            init_err_q  <= init_err_d;
            again_q     <= again_d;
            busy_q      <= (state_d != ST_IDLE);
`ifdef ULPI_REG_INIT_VERIFY_EN
            rd_ph_q     <= rd_ph_d;
`endif
        end
    end

    assign ulpi.ULPI_REG_EN    = (state_q == ST_ISSUE) || (state_q == ST_INIT_ISSUE);
    assign ulpi.ULPI_REG_RW    = op_q.rw;
    assign ulpi.ULPI_REG_ADDR  = op_q.addr;
    assign ulpi.ULPI_REG_WDATA = op_q.wdata;

    assign cl.C_GNT     = gnt_q;
    assign cl.C_DONE    = done_q;
    assign cl.C_ERR     = err_q;
    assign cl.C_RDATA   = rdata_q;
    assign cl.INIT_DONE = init_done_q;
    assign cl.INIT_ERR  = init_err_q;
    assign cl.BUSY      = busy_q;

endmodule

// File: tb/tb_ulpi_reg_sched.sv
// Scoreboard bench for ulpi_reg_sched: expected register ops and client completions
// are queued by the stimulus and popped by independent monitors.
module tb_ulpi_reg_sched;

    localparam int R_DONE   = 0;
    localparam int R_FAIL   = 1;
    localparam int R_SILENT = 2;

    typedef struct {
        logic       rw;
        logic [5:0] addr;
        logic [7:0] wdata;
        logic [1:0] gnt;
    } op_t;

    typedef struct {
        logic [1:0] done;
        logic [1:0] err;
        logic       chk_rd;
        logic [7:0] rdata;
    } cmpl_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ulpi_reg_if    u_if ();
    ulpi_client_if c_if ();

    ulpi_reg_sched #(.TIMEOUT_CYC(16), .MAX_RETRY(3)) dut (
        .CLK_60M   (clk),
        .RST_A_USB (rst),
        .ulpi      (u_if),
        .cl        (c_if)
    );

    op_t        exp_op[$];
    cmpl_t      exp_cmpl[$];
    int         rsp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_cmpl   = 0;
    logic [7:0] phy_rdata = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_op(input logic rw, input logic [5:0] a, input logic [7:0] d,
                           input logic [1:0] g, input int n);
        op_t o;
        o.rw = rw; o.addr = a; o.wdata = d; o.gnt = g;
        for (int i = 0; i < n; i++) exp_op.push_back(o);
    endtask

    task automatic push_cmpl(input logic [1:0] dn, input logic [1:0] er,
                             input logic chk, input logic [7:0] rd);
        cmpl_t c;
        c.done = dn; c.err = er; c.chk_rd = chk; c.rdata = rd;
        exp_cmpl.push_back(c);
    endtask

    task automatic wait_cmpl(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (n_cmpl >= target) break;
            @(posedge clk); #2;
        end
        n_checks++;
        if (n_cmpl < target) begin
            n_fail++;
            $display("FAIL wait_cmpl: got %0d completions, required %0d", n_cmpl, target);
        end
    endtask

    task automatic wait_init(input int budget, output logic early_gnt);
        early_gnt = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (c_if.INIT_DONE === 1'b1) break;
            @(posedge clk); #2;
            if (c_if.C_GNT !== 2'b00 && c_if.INIT_DONE !== 1'b1) early_gnt = 1'b1;
        end
    endtask

    // PHY model: DONE (two cycles long) or FAIL three cycles after each REG_EN, or silence.
    initial begin
        int r;
        u_if.ULPI_REG_DONE  = 1'b0;
        u_if.ULPI_REG_FAIL  = 1'b0;
        u_if.ULPI_REG_RDATA = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (u_if.ULPI_REG_EN === 1'b1 && rst === 1'b0) begin
                r = (rsp_q.size() > 0) ? rsp_q.pop_front() : R_DONE;
                if (r == R_DONE) begin
                    repeat (2) @(posedge clk);
                    #1;
                    u_if.ULPI_REG_DONE  = 1'b1;
                    u_if.ULPI_REG_RDATA = phy_rdata;
                    repeat (2) @(posedge clk);
                    #1;
                    u_if.ULPI_REG_DONE  = 1'b0;
                end else if (r == R_FAIL) begin
                    repeat (2) @(posedge clk);
                    #1;
                    u_if.ULPI_REG_FAIL = 1'b1;
                    @(posedge clk);
                    #1;
                    u_if.ULPI_REG_FAIL = 1'b0;
                end
            end
        end
    end

    // Register-op monitor.
    initial begin
        op_t e;
        forever begin
            @(posedge clk); #1;
            if (u_if.ULPI_REG_EN === 1'b1) begin
                if (exp_op.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_op: got rw=%b addr=0x%0h, none required",
                             u_if.ULPI_REG_RW, u_if.ULPI_REG_ADDR);
                end else begin
                    e = exp_op.pop_front();
                    check("op_rw", u_if.ULPI_REG_RW, e.rw);
                    check("op_addr", u_if.ULPI_REG_ADDR, e.addr);
                    if (e.rw) check("op_wdata", u_if.ULPI_REG_WDATA, e.wdata);
                    check("op_gnt", c_if.C_GNT, e.gnt);
                end
            end
        end
    end

    // Client completion monitor.
    initial begin
        cmpl_t c;
        forever begin
            @(posedge clk); #1;
            if ((c_if.C_DONE | c_if.C_ERR) != 2'b00) begin
                n_cmpl++;
                if (exp_cmpl.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_cmpl: got done=%b err=%b, none required",
                             c_if.C_DONE, c_if.C_ERR);
                end else begin
                    c = exp_cmpl.pop_front();
                    check("c_done", c_if.C_DONE, c.done);
                    check("c_err", c_if.C_ERR, c.err);
                    if (c.chk_rd) check("c_rdata", c_if.C_RDATA, c.rdata);
                    check("gnt_fall", c_if.C_GNT, 2'b00);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not reach the end, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic early;
        rst = 1'b1;
        u_if.ULPI_READY = 1'b1;
        c_if.C_REQ = 2'b00; c_if.C_RW = 2'b00; c_if.C_ADDR = '0; c_if.C_WDATA = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_reg_en", u_if.ULPI_REG_EN, 1'b0);
        check("rst_gnt", c_if.C_GNT, 2'b00);
        check("rst_init_done", c_if.INIT_DONE, 1'b0);
        check("rst_busy", c_if.BUSY, 1'b0);

        // Init table, with client 1 already requesting: no grant before INIT_DONE.
        push_op(1'b1, 6'h04, 8'h65, 2'b00, 1);
        push_op(1'b1, 6'h07, 8'h00, 2'b00, 1);
        push_op(1'b1, 6'h0A, 8'h00, 2'b00, 1);
        push_op(1'b1, 6'h15, 8'h3C, 2'b10, 1);
        push_cmpl(2'b10, 2'b00, 1'b0, 8'h00);
        c_if.C_REQ = 2'b10; c_if.C_RW = 2'b10;
        c_if.C_ADDR = {6'h15, 6'h00}; c_if.C_WDATA = {8'h3C, 8'h00};
        @(negedge clk);
        rst = 1'b0;
        wait_init(400, early);
        check("init_done", c_if.INIT_DONE, 1'b1);
        check("init_err", c_if.INIT_ERR, 1'b0);
        check("early_gnt", early, 1'b0);
        wait_cmpl(1, 200);
        c_if.C_REQ = 2'b00;

        // Both clients requesting: alternate 0,1,0,1.
        push_op(1'b1, 6'h11, 8'hA1, 2'b01, 1);
        push_op(1'b1, 6'h22, 8'hB2, 2'b10, 1);
        push_op(1'b1, 6'h11, 8'hA1, 2'b01, 1);
        push_op(1'b1, 6'h22, 8'hB2, 2'b10, 1);
        push_cmpl(2'b01, 2'b00, 1'b0, 8'h00);
        push_cmpl(2'b10, 2'b00, 1'b0, 8'h00);
        push_cmpl(2'b01, 2'b00, 1'b0, 8'h00);
        push_cmpl(2'b10, 2'b00, 1'b0, 8'h00);
        c_if.C_RW = 2'b11; c_if.C_ADDR = {6'h22, 6'h11}; c_if.C_WDATA = {8'hB2, 8'hA1};
        c_if.C_REQ = 2'b11;
        wait_cmpl(5, 400);
        c_if.C_REQ = 2'b00;

        // Client 1 read, held off while READY is low.
        u_if.ULPI_READY = 1'b0;
        phy_rdata = 8'h24;
        push_op(1'b0, 6'h00, 8'h00, 2'b10, 1);
        push_cmpl(2'b10, 2'b00, 1'b1, 8'h24);
        c_if.C_RW = 2'b00; c_if.C_ADDR = 12'h000; c_if.C_REQ = 2'b10;
        repeat (8) @(posedge clk);
        #2;
        check("ready_low_gnt", c_if.C_GNT, 2'b00);
        u_if.ULPI_READY = 1'b1;
        wait_cmpl(6, 200);
        c_if.C_REQ = 2'b00;
        phy_rdata = 8'h00;
        repeat (5) @(posedge clk);
        #2;
        check("rdata_hold", c_if.C_RDATA, 8'h24);

        // Two FAILs then DONE: three attempts, success.
        rsp_q.push_back(R_FAIL); rsp_q.push_back(R_FAIL);
        push_op(1'b1, 6'h2A, 8'h55, 2'b01, 3);
        push_cmpl(2'b01, 2'b00, 1'b0, 8'h00);
        c_if.C_RW = 2'b01; c_if.C_ADDR = {6'h00, 6'h2A}; c_if.C_WDATA = {8'h00, 8'h55};
        c_if.C_REQ = 2'b01;
        wait_cmpl(7, 300);
        c_if.C_REQ = 2'b00;

        // FAIL on every attempt: four attempts, then error pulse.
        for (int i = 0; i < 4; i++) rsp_q.push_back(R_FAIL);
        push_op(1'b1, 6'h2B, 8'h66, 2'b10, 4);
        push_cmpl(2'b00, 2'b10, 1'b0, 8'h00);
        c_if.C_RW = 2'b10; c_if.C_ADDR = {6'h2B, 6'h00}; c_if.C_WDATA = {8'h66, 8'h00};
        c_if.C_REQ = 2'b10;
        wait_cmpl(8, 300);
        c_if.C_REQ = 2'b00;
        repeat (8) @(posedge clk);
        #2;
        check("idle_busy", c_if.BUSY, 1'b0);

        // Async reset while waiting on a silent PHY.
        rsp_q.push_back(R_SILENT);
        push_op(1'b1, 6'h30, 8'h77, 2'b01, 1);
        c_if.C_RW = 2'b01; c_if.C_ADDR = {6'h00, 6'h30}; c_if.C_WDATA = {8'h00, 8'h77};
        c_if.C_REQ = 2'b01;
        for (int i = 0; i < 100; i++) begin
            if (exp_op.size() == 0) break;
            @(posedge clk); #2;
        end
        check("silent_op_issued", exp_op.size(), 0);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_reg_en", u_if.ULPI_REG_EN, 1'b0);
        check("arst_gnt", c_if.C_GNT, 2'b00);
        check("arst_busy", c_if.BUSY, 1'b0);
        check("arst_init_done", c_if.INIT_DONE, 1'b0);
        check("arst_done", c_if.C_DONE, 2'b00);
        c_if.C_REQ = 2'b00;
        rsp_q.delete();
        exp_op.delete();

        // Restarted init with entry 1 unanswered: four attempts then INIT_ERR, entry 2 still runs.
        rsp_q.push_back(R_DONE);
        for (int i = 0; i < 4; i++) rsp_q.push_back(R_SILENT);
        push_op(1'b1, 6'h04, 8'h65, 2'b00, 1);
        push_op(1'b1, 6'h07, 8'h00, 2'b00, 4);
        push_op(1'b1, 6'h0A, 8'h00, 2'b00, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_init(600, early);
        check("init2_done", c_if.INIT_DONE, 1'b1);
        check("init2_err", c_if.INIT_ERR, 1'b1);
        repeat (10) @(posedge clk);
        #2;
        check("ops_left", exp_op.size(), 0);
        check("cmpl_left", exp_cmpl.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
